// File: rtl/coef_set_loader.sv
// coef_set_loader: streams one of nine fixed 3x3 kernel coefficient sets from an
// internal ROM over a valid/ready bus, followed by a set-index commit beat.
// Optional feature macro: COEF_LOADER_CHKSUM_EN adds a modulo-2^DATA_W checksum
// output covering the k1..k9 beats of the most recent transfer.
module coef_set_loader #(
  parameter int DATA_W   = 16,
  parameter int NUM_SETS = 9,
  parameter int SET_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [SET_W-1:0]  load_set,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [3:0]        coef_addr,
  output logic [DATA_W-1:0] coef_data,
  output logic              coef_last
`ifdef COEF_LOADER_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  typedef enum logic [1:0] {IDLE, SEND, COMMIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         beat_q, beat_d;
  logic               err_q, err_d;
  logic [SET_W-1:0]   set_q;
  logic               accept;
  logic               hs;
  logic signed [DATA_W-1:0] kcoef;

  // Fixed coefficient ROM; k1 sits in the most significant 16 bits of each row.
  function automatic logic signed [DATA_W-1:0] rom_coef(input logic [SET_W-1:0] set,
                                                        input logic [3:0] k);
    logic [143:0]       row;
    logic [143:0]       sh;
    logic signed [15:0] w;
    case (set)
      4'd0:    row = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h03E8,
                      16'h0000, 16'h0000, 16'h0000, 16'h0000};
      4'd1:    row = {16'h0101, 16'h01F8, 16'h0062, 16'hFF6C, 16'hFEDD,
                      16'h01B7, 16'h01B7, 16'hFE90, 16'hFFB9};
      4'd2:    row = {16'h05DC, 16'hFF06, 16'hFF06, 16'hFF06, 16'h05DC,
                      16'hFF06, 16'hFF06, 16'hFF06, 16'h05DC};
      4'd3:    row = {16'h0000, 16'hFE0C, 16'h0000, 16'hFE0C, 16'h0BB8,
                      16'hFE0C, 16'h0000, 16'hFE0C, 16'h0000};
      4'd4:    row = {9{16'h006F}};
      4'd5:    row = {16'hFC18, 16'h0000, 16'h03E8, 16'hF830, 16'h0000,
                      16'h07D0, 16'hFC18, 16'h0000, 16'h03E8};
      4'd6:    row = {16'h03E8, 16'h07D0, 16'h03E8, 16'h0000, 16'h0000,
                      16'h0000, 16'hFC18, 16'hF830, 16'hFC18};
      4'd7:    row = {16'hFC18, 16'hFC18, 16'h0000, 16'hFC18, 16'h0000,
                      16'h03E8, 16'h0000, 16'h03E8, 16'h03E8};
      4'd8:    row = {16'h055F, 16'hFF83, 16'hFF06, 16'hFF06, 16'h055F,
                      16'hFF83, 16'hFF83, 16'hFF06, 16'h055F};
      default: row = '0;
    endcase
    sh = row >> {(4'd9 - k), 4'b0000};
    w  = sh[15:0];
    return DATA_W'(w);
  endfunction

  assign accept = (state_q == IDLE) && load_req && (load_set < SET_W'(NUM_SETS));
  assign hs     = coef_valid && coef_ready;
  assign kcoef  = rom_coef(set_q, beat_q);

  // Bus outputs decode straight from state so an asynchronous reset clears them at once.
  always_comb begin
    coef_valid = 1'b0;
    coef_addr  = 4'd0;
    coef_data  = '0;
    coef_last  = 1'b0;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    err        = err_q;
    case (state_q)
      SEND: begin
        coef_valid = 1'b1;
        coef_addr  = beat_q;
        coef_data  = kcoef;
      end
      COMMIT: begin
        coef_valid = 1'b1;
        coef_addr  = 4'd10;
        coef_data  = DATA_W'(set_q);
        coef_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic: requests are only looked at in IDLE, so busy/DONE cycles drop them.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          beat_d  = 4'd1;
        end else if (load_req) begin
          err_d = 1'b1;
        end
      end
      SEND: begin
        if (hs) begin
          if (beat_q == 4'd9) state_d = COMMIT;
          else                beat_d  = beat_q + 4'd1;
        end
      end
      COMMIT: begin
        if (hs) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Set index captured once at acceptance; later load_set changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) set_q <= load_set;
  end

`ifdef COEF_LOADER_CHKSUM_EN
  logic [DATA_W-1:0] chksum_q;

  // Running sum of k1..k9 beats, cleared when a new transfer is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           chksum_q <= '0;
    else if (accept)                   chksum_q <= '0;
    else if ((state_q == SEND) && hs)  chksum_q <= chksum_q + coef_data;
  end

  assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_coef_set_loader.sv
// Directed bench for coef_set_loader; expected beats come from a hand-typed ROM table.
// Optional feature macro: COEF_LOADER_CHKSUM_EN enables the checksum comparisons.
module tb_coef_set_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic [3:0]  load_set = 4'd0;
  logic        busy, done, err, coef_valid;
  logic        coef_ready = 1'b0;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_last;
`ifdef COEF_LOADER_CHKSUM_EN
  logic [15:0] chksum;
`endif

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [15:0] rom [9][9] = '{
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h03E8, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
    '{16'h0101, 16'h01F8, 16'h0062, 16'hFF6C, 16'hFEDD, 16'h01B7, 16'h01B7, 16'hFE90, 16'hFFB9},
    '{16'h05DC, 16'hFF06, 16'hFF06, 16'hFF06, 16'h05DC, 16'hFF06, 16'hFF06, 16'hFF06, 16'h05DC},
    '{16'h0000, 16'hFE0C, 16'h0000, 16'hFE0C, 16'h0BB8, 16'hFE0C, 16'h0000, 16'hFE0C, 16'h0000},
    '{16'h006F, 16'h006F, 16'h006F, 16'h006F, 16'h006F, 16'h006F, 16'h006F, 16'h006F, 16'h006F},
    '{16'hFC18, 16'h0000, 16'h03E8, 16'hF830, 16'h0000, 16'h07D0, 16'hFC18, 16'h0000, 16'h03E8},
    '{16'h03E8, 16'h07D0, 16'h03E8, 16'h0000, 16'h0000, 16'h0000, 16'hFC18, 16'hF830, 16'hFC18},
    '{16'hFC18, 16'hFC18, 16'h0000, 16'hFC18, 16'h0000, 16'h03E8, 16'h0000, 16'h03E8, 16'h03E8},
    '{16'h055F, 16'hFF83, 16'hFF06, 16'hFF06, 16'h055F, 16'hFF83, 16'hFF83, 16'hFF06, 16'h055F}
  };

  coef_set_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .load_set   (load_set),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_last  (coef_last)
`ifdef COEF_LOADER_CHKSUM_EN
    ,
    .chksum     (chksum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, coef_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},       32'd0);
    check({tag, "_done"},  {31'd0, done},       32'd0);
    check({tag, "_addr"},  {28'd0, coef_addr},  32'd0);
    check({tag, "_data"},  {16'd0, coef_data},  32'd0);
    check({tag, "_last"},  {31'd0, coef_last},  32'd0);
  endtask

  // mode 0: ready held high; mode 1: ready toggles each cycle.
  // inj_beat>0 drives a second request while that beat is on the bus.
  // chain>=0 drives a request for that set during the DONE cycle.
  task automatic run_xfer(input int s, input int mode, input int inj_beat, input int inj_set,
                          input int chain, input logic [15:0] exp_sum);
    int b = 1;
    int n = 0;
    int c0;
    logic hs;
    logic injected = 1'b0;
    logic [15:0] ed;
    load_req = 1'b1;
    load_set = 4'(s);
    c0 = cyc;
    tick();
    load_req = 1'b0;
    load_set = 4'(inj_set);
    while (b <= 10 && n < 200) begin
      if (inj_beat == b && !injected) begin
        load_req = 1'b1;
        injected = 1'b1;
      end else begin
        load_req = 1'b0;
      end
      coef_ready = (mode == 0) ? 1'b1 : logic'(cyc[0]);
      ed = (b <= 9) ? rom[s][b-1] : 16'(s);
      check($sformatf("s%0d_b%0d_valid", s, b), {31'd0, coef_valid}, 32'd1);
      check($sformatf("s%0d_b%0d_busy", s, b),  {31'd0, busy},       32'd1);
      check($sformatf("s%0d_b%0d_addr", s, b),  {28'd0, coef_addr},  32'(b));
      check($sformatf("s%0d_b%0d_data", s, b),  {16'd0, coef_data},  {16'd0, ed});
      check($sformatf("s%0d_b%0d_last", s, b),  {31'd0, coef_last},  {31'd0, (b == 10)});
      hs = coef_ready;
      tick();
      n++;
      if (hs) b++;
    end
    load_req = 1'b0;
    coef_ready = 1'b0;
    if (b <= 10) check($sformatf("s%0d_beat_timeout", s), 32'(b), 32'd11);
    check($sformatf("s%0d_done", s),       {31'd0, done},       32'd1);
    check($sformatf("s%0d_done_busy", s),  {31'd0, busy},       32'd1);
    check($sformatf("s%0d_done_valid", s), {31'd0, coef_valid}, 32'd0);
    if (mode == 0) check($sformatf("s%0d_latency", s), 32'(cyc - c0), 32'd11);
`ifdef COEF_LOADER_CHKSUM_EN
    check($sformatf("s%0d_chksum", s), {16'd0, chksum}, {16'd0, exp_sum});
`endif
    if (chain >= 0) begin
      load_req = 1'b1;
      load_set = 4'(chain);
    end
    tick();
    check_idle($sformatf("s%0d_after", s));
`ifdef COEF_LOADER_CHKSUM_EN
    check($sformatf("s%0d_chksum_hold", s), {16'd0, chksum}, {16'd0, exp_sum});
`else
    if (exp_sum == 16'hFFFF) check("unused_sum", 32'd0, 32'd1);
`endif
  endtask

  task automatic bad_req(input int s);
    load_req = 1'b1;
    load_set = 4'(s);
    tick();
    load_req = 1'b0;
    check($sformatf("err%0d_pulse", s), {31'd0, err},        32'd1);
    check($sformatf("err%0d_busy", s),  {31'd0, busy},       32'd0);
    check($sformatf("err%0d_valid", s), {31'd0, coef_valid}, 32'd0);
    tick();
    check($sformatf("err%0d_clear", s), {31'd0, err},        32'd0);
    check($sformatf("err%0d_valid2", s), {31'd0, coef_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_idle("reset");
    check("reset_err", {31'd0, err}, 32'd0);
`ifdef COEF_LOADER_CHKSUM_EN
    check("reset_chksum", {16'd0, chksum}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Set 4, ready high; set 3, ready toggling
    run_xfer(4, 0, 0, 0, -1, 16'h03E7);
    tick();
    run_xfer(3, 1, 0, 0, -1, 16'h03E8);
    tick();

    // Invalid indices
    bad_req(9);
    bad_req(15);

    // Set 5 with an ignored second request at beat 4
    run_xfer(5, 0, 4, 6, -1, 16'h0000);
    tick();

    // Set 1 aborted by asynchronous reset while beat 6 is stalled
    load_req = 1'b1;
    load_set = 4'd1;
    tick();
    load_req = 1'b0;
    coef_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    coef_ready = 1'b0;
    check("abort_addr6", {28'd0, coef_addr}, 32'd6);
    check("abort_data6", {16'd0, coef_data}, 32'h01B7);
    #2;
    rst = 1'b1;
    #1;
    check_idle("abort_async");
`ifdef COEF_LOADER_CHKSUM_EN
    check("abort_chksum", {16'd0, chksum}, 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check_idle("abort_post");
    run_xfer(0, 0, 0, 0, -1, 16'h03E8);
    tick();

    // Set 2, then set 8 requested in the DONE cycle (ignored) and the next (accepted)
    run_xfer(2, 0, 0, 0, 8, 16'h0BB8);
    run_xfer(8, 1, 0, 0, -1, 16'h0BB8);
    tick();
    check_idle("final");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/coef_set_loader.md
Name: coef_set_loader

Overview:
Transmit side of the 3x3 kernel coefficient write interface. On a load request, it looks up one of nine fixed coefficient sets (indices 0..8) in an internal ROM. It then streams the nine signed 16-bit coefficients, followed by a set-index commit beat, over a valid/ready bus into the filter kernel's coefficient register bank. It sits between the host/config register block and the kernel filter stage.

Parameters:
DATA_W, 16, coefficient width; signed two's complement, scaled x1000 (1.000 = 16'h03E8)
NUM_SETS, 9, number of ROM sets; valid indices 0..NUM_SETS-1
SET_W, 4, width of set index fields

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
load_req  in  1  single-cycle request to load a set
load_set  in  SET_W  set index, sampled when load_req=1 and the block accepts it
busy  out  1  high from request acceptance until the done pulse, inclusive
done  out  1  one-cycle pulse when the commit beat has handshaken
err  out  1  one-cycle pulse when a request has an invalid index
coef_valid  out  1  beat valid
coef_ready  in  1  sink ready
coef_addr  out  4  beat address: 1..9 = k1..k9; 10 = kSet commit
coef_data  out  DATA_W  coefficient value, or the zero-extended set index on the commit beat
coef_last  out  1  high on the commit beat only

Behaviour:
- Reset values: busy=0, done=0, err=0, coef_valid=0, coef_addr=0, coef_data=0, coef_last=0. The FSM enters IDLE. Reset asserted mid-transfer aborts the transfer immediately; no partial commit beat is issued.
- ROM contents, index: k1..k9
  - 0 (disable): 0,0,0,0,03E8,0,0,0,0
  - 1 (YCbCr): 0101,01F8,0062,FF6C,FEDD,01B7,01B7,FE90,FFB9
  - 2 (cgain): 05DC,FF06,FF06,FF06,05DC,FF06,FF06,FF06,05DC
  - 3 (sharp): 0000,FE0C,0000,FE0C,0BB8,FE0C,0000,FE0C,0000
  - 4 (blur): all nine = 006F
  - 5 (sobel X): FC18,0000,03E8,F830,0000,07D0,FC18,0000,03E8
  - 6 (sobel Y): 03E8,07D0,03E8,0000,0000,0000,FC18,F830,FC18
  - 7 (emboss): FC18,FC18,0000,FC18,0000,03E8,0000,03E8,03E8
  - 8 (cgain1): 055F,FF83,FF06,FF06,055F,FF83,FF83,FF06,055F
- FSM states: IDLE, SEND, COMMIT, DONE.
  - IDLE: on load_req with load_set<NUM_SETS, latch the index, set busy=1 and go to SEND. On load_req with load_set>=NUM_SETS, pulse err for 1 cycle and stay in IDLE with no beats.
  - SEND: the beat counter runs 1..9. A beat completes on coef_valid&coef_ready. After beat 9 completes, go to COMMIT.
  - COMMIT: addr=10, data=latched index, last=1. On handshake, go to DONE.
  - DONE: done=1 and busy=1 for one cycle, then go to IDLE with busy=0.
- Latency: a request accepted at cycle N gives first coef_valid at N+1. With coef_ready held high, beats occupy N+1..N+10 and done pulses at N+11. A new request is accepted from N+12.
- Handshake rules:
  - coef_valid, once high, holds with addr/data/last stable until ready is sampled high.
  - Valid never drops mid-transfer. Ready may toggle arbitrarily, and stalls are unbounded.
  - Valid is deasserted in the cycle after the commit handshake.
- load_req while busy: ignored, with no err and no queueing.
- load_req coincident with the DONE cycle: ignored.
- Index is latched at acceptance; load_set changes afterwards have no effect.

Optional Feature:
COEF_LOADER_CHKSUM_EN
- Defined: adds output chksum [DATA_W-1:0].
  - Cleared to 0 at request acceptance.
  - Accumulates coef_data modulo 2^DATA_W on each k1..k9 handshake.
  - Valid and stable from the done pulse until the next acceptance.
  - Reset value is 0.
- Undefined: the port and accumulator are absent, and all other behaviour is identical.

Test Plan:
- Request set 4, ready held high -> beats addr 1..9 all data 16'h006F, then addr 10 data 16'h0004 last=1. done at N+11. Chksum 16'h03E7.
- Request set 3, ready toggling 1/0 each cycle -> data stable during stalls, same 10 beats. Chksum 16'h03E8 (3000-4*500).
- Request set 9 and set 15 -> err pulse 1 cycle each, coef_valid stays 0, busy stays 0.
- Request set 5, then a second load_req set 6 at beat 4 -> second request ignored. Commit data=16'h0005, chksum 16'h0000.
- Request set 1, assert rst during beat 6 while stalled -> all outputs 0 asynchronously, no commit beat. A subsequent set 0 load sends k5=16'h03E8 only, with other beats zero.
- Back-to-back: set 2, then load_req set 8 exactly at the done cycle (ignored) and again one cycle later (accepted) -> a single set-8 transfer follows.
